// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Constants and helpers shared by the PS/2 keyboard receive path.
//   PS2_BREAK       : break (key release) prefix byte
//   PS2_EXT         : extended-key prefix byte
//   PS2_FRAME_BITS  : start + 8 data + parity + stop
//   byte_kind_e     : classification of a received byte
//   classify_byte() : maps a byte to its byte_kind_e
//   frame_ok()      : start/stop/odd-parity check of a complete frame
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;
    localparam int         PS2_CNT_W      = 4;

    typedef enum logic [1:0] {
        BYTE_CODE  = 2'd0,
        BYTE_BREAK = 2'd1,
        BYTE_EXT   = 2'd2
    } byte_kind_e;

    function automatic byte_kind_e classify_byte(input logic [7:0] b);
        byte_kind_e kind;
        kind = BYTE_CODE;
        if (b == PS2_BREAK) begin
            kind = BYTE_BREAK;
        end else if (b == PS2_EXT) begin
            kind = BYTE_EXT;
        end
        return kind;
    endfunction

    // Data bits plus parity must carry an odd number of ones.
    function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
        return (f[0] == 1'b0) && (f[PS2_FRAME_BITS-1] == 1'b1) && (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 frame receiver: synchronizes the device clock/data, detects falling
// edges of the device clock, shifts in an 11-bit frame, checks it and emits
// the data byte with a one-cycle valid strobe. A partial frame is abandoned
// when no falling edge arrives for TIMEOUT_CYCLES clk cycles.
// Ports:
//   clk, rst_n      : system clock, async active-low reset
//   i_ps2_clk       : PS/2 device clock (asynchronous)
//   i_ps2_data      : PS/2 device data (asynchronous)
//   o_byte[7:0]     : last valid received byte
//   o_byte_valid    : one-cycle strobe, o_byte holds a new valid byte
// ---------------------------------------------------------------------------
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PS2_CNT_W-1:0] LAST_BIT = PS2_CNT_W'(PS2_FRAME_BITS - 1);

    logic                      r_clk_meta;
    logic                      r_clk_sync;
    logic                      r_clk_prev;
    logic                      r_data_meta;
    logic                      r_data_sync;
    logic [PS2_CNT_W-1:0]      r_bit_cnt;
    // Only bits 0..9 are stored; the stop bit is taken straight from the
    // synchronizer when the frame completes.
    logic [PS2_FRAME_BITS-2:0] r_frame;
    logic [TMR_W-1:0]          r_timer;
    logic [7:0]                r_byte;
    logic                      r_byte_valid;

    logic                      w_fall;
    logic                      w_last;
    logic                      w_timeout;
    logic [PS2_FRAME_BITS-1:0] w_frame_full;

    assign w_fall       = r_clk_prev & ~r_clk_sync;
    assign w_last       = (r_bit_cnt == LAST_BIT);
    assign w_timeout    = (r_bit_cnt != '0) && (r_timer == '0);
    assign w_frame_full = {r_data_sync, r_frame};

    // Synchronizers reset to 1 so an idle bus does not look like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= i_ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= i_ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_frame      <= '0;
            r_timer      <= '0;
            r_byte       <= 8'h00;
            r_byte_valid <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            if (w_fall) begin
                r_timer <= TMR_W'(TIMEOUT_CYCLES);
                if ((r_bit_cnt == '0) && r_data_sync) begin
                    // Not a start bit: stay idle and wait for a real one.
                    r_bit_cnt <= '0;
                end else if (w_last) begin
                    r_bit_cnt <= '0;
                    if (frame_ok(w_frame_full)) begin
                        r_byte       <= w_frame_full[8:1];
                        r_byte_valid <= 1'b1;
                    end
                end else begin
                    r_frame[r_bit_cnt] <= r_data_sync;
                    r_bit_cnt          <= r_bit_cnt + PS2_CNT_W'(1);
                end
            end else if (w_timeout) begin
                r_bit_cnt <= '0;
                r_frame   <= '0;
            end else if (r_bit_cnt != '0) begin
                r_timer <= r_timer - TMR_W'(1);
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;

endmodule

// File: rtl/ps2_keyboard_driver.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_driver
// PS/2 keyboard front end: receives bytes through ps2_rx, folds the break
// (F0) and extended (E0) prefixes into flags, and presents each completed
// key event on data/rls_out/xpd_out with a one-cycle done strobe.
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   ps2k_clk    : PS/2 device clock (asynchronous)
//   ps2k_data   : PS/2 device data (asynchronous)
//   rls_out     : key event is a release
//   done        : one-cycle strobe, a new key event is on the outputs
//   xpd_out     : key event is an extended (E0) key
//   data[7:0]   : scan code of the last key event
// ---------------------------------------------------------------------------
module ps2_keyboard_driver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2k_clk,
    input  logic       ps2k_data,
    output logic       rls_out,
    output logic       done,
    output logic       xpd_out,
    output logic [7:0] data
);

    logic [7:0] w_byte;
    logic       w_byte_valid;

    logic       r_rls_flag;
    logic       r_ext_flag;
    logic [7:0] r_data;
    logic       r_rls;
    logic       r_xpd;
    logic       r_done;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ps2_clk    (ps2k_clk),
        .i_ps2_data   (ps2k_data),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid)
    );

    // Prefix flags only ever change on a valid byte, so a bad frame or a
    // timeout leaves any pending prefix in place for the next key code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rls_flag <= 1'b0;
            r_ext_flag <= 1'b0;
            r_data     <= 8'h00;
            r_rls      <= 1'b0;
            r_xpd      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_byte_valid) begin
                case (classify_byte(w_byte))
                    BYTE_BREAK: r_rls_flag <= 1'b1;
                    BYTE_EXT:   r_ext_flag <= 1'b1;
                    default: begin
                        r_data     <= w_byte;
                        r_rls      <= r_rls_flag;
                        r_xpd      <= r_ext_flag;
                        r_done     <= 1'b1;
                        r_rls_flag <= 1'b0;
                        r_ext_flag <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data    = r_data;
    assign rls_out = r_rls;
    assign xpd_out = r_xpd;
    assign done    = r_done;

endmodule

// File: tb/tb_ps2_keyboard_driver.sv
module tb_ps2_keyboard_driver;

    typedef struct {
        logic [7:0] d;
        logic       r;
        logic       x;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ps2k_clk;
    logic       ps2k_data;
    logic       rls_out;
    logic       done;
    logic       xpd_out;
    logic [7:0] data;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];

    ps2_keyboard_driver #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2k_clk  (ps2k_clk),
        .ps2k_data (ps2k_data),
        .rls_out   (rls_out),
        .done      (done),
        .xpd_out   (xpd_out),
        .data      (data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Odd parity computed here from the byte; bad_par flips it.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2k_data = f[i];
            #80 ps2k_clk = 1'b0;
            #80 ps2k_clk = 1'b1;
        end
        ps2k_data = 1'b1;
        #400;
    endtask

    task automatic send_key(input logic [7:0] b, input logic r, input logic x);
        exp_t e;
        e.d = b;
        e.r = r;
        e.x = x;
        sb.push_back(e);
        send_frame(b, 1'b0, 11);
    endtask

    task automatic drain_and_check(input string tag, input int exp_done,
                                   input logic [7:0] d, input logic r, input logic x);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        check({tag, "_drain"}, sb.size(), 0);
        check({tag, "_done_cnt"}, n_done, exp_done);
        check({tag, "_data"}, data, d);
        check({tag, "_rls"}, rls_out, r);
        check({tag, "_xpd"}, xpd_out, x);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            n_done++;
            check("done_width", prev_done, 0);
            check("sb_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_data", data, e.d);
                check("sb_rls", rls_out, e.r);
                check("sb_xpd", xpd_out, e.x);
            end
        end
        prev_done = done;
    end

    initial begin
        rst_n     = 1'b0;
        ps2k_clk  = 1'b1;
        ps2k_data = 1'b1;
        #45;
        check("rst_data", data, 8'h00);
        check("rst_rls", rls_out, 0);
        check("rst_xpd", xpd_out, 0);
        check("rst_done", done, 0);
        #60 rst_n = 1'b1;
        #200;

        // Break then code: single event after the code byte
        send_frame(8'hF0, 1'b0, 11);
        check("f0_no_done", n_done, 0);
        send_key(8'h1C, 1'b1, 1'b0);
        drain_and_check("brk", 1, 8'h1C, 1'b1, 1'b0);

        // Plain make code
        send_key(8'h1C, 1'b0, 1'b0);
        drain_and_check("make", 2, 8'h1C, 1'b0, 1'b0);

        // Extended release, then flags are cleared for the next key
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_key(8'h75, 1'b1, 1'b1);
        drain_and_check("ext_rel", 3, 8'h75, 1'b1, 1'b1);
        send_key(8'h1C, 1'b0, 1'b0);
        drain_and_check("after_ext", 4, 8'h1C, 1'b0, 1'b0);

        // Prefixes in the other order, repeated
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'hE0, 1'b0, 11);
        send_key(8'h6B, 1'b1, 1'b1);
        drain_and_check("pfx_order", 5, 8'h6B, 1'b1, 1'b1);

        // Bad parity: dropped, outputs held; next good frame accepted
        send_frame(8'h1C, 1'b1, 11);
        drain_and_check("bad_par", 5, 8'h6B, 1'b1, 1'b1);
        send_key(8'h1C, 1'b0, 1'b0);
        drain_and_check("good_after_bad", 6, 8'h1C, 1'b0, 1'b0);

        // Pending break survives a bad frame
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h75, 1'b1, 11);
        drain_and_check("bad_keep_pfx", 6, 8'h1C, 1'b0, 1'b0);
        send_key(8'h74, 1'b1, 1'b0);
        drain_and_check("pfx_kept", 7, 8'h74, 1'b1, 1'b0);

        // Partial frame then timeout
        send_frame(8'h75, 1'b0, 5);
        #3000;
        send_key(8'h1C, 1'b0, 1'b0);
        drain_and_check("timeout", 8, 8'h1C, 1'b0, 1'b0);

        // Reset mid-frame
        send_key(8'h5A, 1'b0, 1'b0);
        drain_and_check("pre_rst", 9, 8'h5A, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_rls", rls_out, 0);
        check("midrst_xpd", xpd_out, 0);
        check("midrst_done", done, 0);
        #100 rst_n = 1'b1;
        #200;
        send_key(8'h1C, 1'b0, 1'b0);
        drain_and_check("post_rst", 10, 8'h1C, 1'b0, 1'b0);

        #200;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
